// File: rtl/leg_fetch_queue_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch queue.
package leg_fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BYTE_CNT_W = 2;

  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/leg_fetch_queue_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head output.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_head_valid,
  output logic [DATA_W-1:0]        o_head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [PTR_W:0]    w_wr_ptr_n;
  logic [PTR_W:0]    w_rd_ptr_n;
  logic [PTR_W:0]    w_count_after_pop;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_head_valid;
  logic [DATA_W-1:0] r_head_data;
  logic              w_head_valid_n;
  logic [DATA_W-1:0] w_head_data_n;
  logic              w_push;
  logic              w_pop;

  assign o_count      = r_wr_ptr - r_rd_ptr;
  assign o_full       = (o_count == (PTR_W+1)'(DEPTH));
  assign o_empty      = (o_count == '0);
  assign w_push       = i_push && !o_full && !i_flush;
  assign w_pop        = i_pop && !o_empty && !i_flush;
  assign o_head_valid = r_head_valid;
  assign o_head_data  = r_head_data;

  // Next pointers and next head; a push into an empty (or just-emptied) FIFO becomes the head directly.
  always_comb begin
    w_wr_ptr_n        = r_wr_ptr;
    w_rd_ptr_n        = r_rd_ptr;
    w_head_valid_n    = 1'b0;
    w_head_data_n     = '0;
    w_count_after_pop = o_count - (PTR_W+1)'(w_pop);
    if (i_flush) begin
      w_wr_ptr_n = '0;
      w_rd_ptr_n = '0;
    end else begin
      if (w_push) w_wr_ptr_n = r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  w_rd_ptr_n = r_rd_ptr + (PTR_W+1)'(1);
      if (w_push && (w_count_after_pop == '0)) begin
        w_head_valid_n = 1'b1;
        w_head_data_n  = i_wdata;
      end else if (w_count_after_pop != '0) begin
        w_head_valid_n = 1'b1;
        w_head_data_n  = r_mem[w_rd_ptr_n[PTR_W-1:0]];
      end
    end
  end

  // Entry storage; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
  end

  // Pointer and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_n;
      r_rd_ptr     <= w_rd_ptr_n;
      r_head_valid <= w_head_valid_n;
      r_head_data  <= w_head_data_n;
    end
  end

endmodule

// File: rtl/leg_fetch_queue.sv
// Byte-serial instruction fetch: assembles big-endian words and queues them with their PCs.
module leg_fetch_queue
  import leg_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_data,
  input  logic               mem_ack,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction_word,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned DATA_W  = INSTR_W + ADDR_W;
  localparam int unsigned COUNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PART_W  = INSTR_W - BYTE_W;

  fetch_state_e           r_state;
  fetch_state_e           w_state_n;
  logic [ADDR_W-1:0]      r_fetch_pc;
  logic [ADDR_W-1:0]      w_fetch_pc_n;
  logic [BYTE_CNT_W-1:0]  r_byte_cnt;
  logic [BYTE_CNT_W-1:0]  w_byte_cnt_n;
  logic [PART_W-1:0]      r_part;
  logic [PART_W-1:0]      w_part_n;
  logic                   r_mem_req;
  logic                   w_mem_req_n;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [ADDR_W-1:0]      w_mem_addr_n;
  logic                   w_ack;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_W-1:0]      w_push_data;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [COUNT_W-1:0]     w_fifo_count;
  logic                   w_head_valid;
  logic [DATA_W-1:0]      w_head_data;

  assign w_ack       = r_mem_req && mem_ack;
  assign w_pop       = instr_ready && !w_fifo_empty;
  assign w_push_data = {r_part, mem_data, r_fetch_pc};

  // Next-state logic for the fetch FSM, byte assembler and PC counter; redirect overrides everything.
  always_comb begin
    w_state_n    = r_state;
    w_fetch_pc_n = r_fetch_pc;
    w_byte_cnt_n = r_byte_cnt;
    w_part_n     = r_part;
    w_mem_req_n  = r_mem_req;
    w_mem_addr_n = r_mem_addr;
    w_push       = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_mem_req_n = 1'b1;
        if (w_ack) begin
          case (r_byte_cnt)
            2'd0:    w_part_n[23:16] = mem_data;
            2'd1:    w_part_n[15:8]  = mem_data;
            2'd2:    w_part_n[7:0]   = mem_data;
            default: w_push          = 1'b1;
          endcase
          w_byte_cnt_n = r_byte_cnt + BYTE_CNT_W'(1);
          if (w_push) w_fetch_pc_n = r_fetch_pc + ADDR_W'(WORD_BYTES);
        end
        if (w_push && !w_pop && (w_fifo_count == COUNT_W'(DEPTH - 1))) begin
          w_state_n   = STALL;
          w_mem_req_n = 1'b0;
        end else begin
          w_mem_addr_n = w_fetch_pc_n + ADDR_W'(w_byte_cnt_n);
        end
      end
      STALL: begin
        w_mem_req_n = 1'b0;
        if (!w_fifo_full) begin
          w_state_n    = FETCH;
          w_mem_req_n  = 1'b1;
          w_mem_addr_n = r_fetch_pc + ADDR_W'(r_byte_cnt);
        end
      end
      default: w_state_n = FETCH;
    endcase
    if (redirect_valid) begin
      w_state_n    = FETCH;
      w_fetch_pc_n = redirect_pc;
      w_byte_cnt_n = '0;
      w_part_n     = '0;
      w_mem_req_n  = 1'b1;
      w_mem_addr_n = redirect_pc;
      w_push       = 1'b0;
    end
  end

  // State and registered memory-side outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= FETCH;
      r_fetch_pc <= '0;
      r_byte_cnt <= '0;
      r_part     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_n;
      r_fetch_pc <= w_fetch_pc_n;
      r_byte_cnt <= w_byte_cnt_n;
      r_part     <= w_part_n;
      r_mem_req  <= w_mem_req_n;
      r_mem_addr <= w_mem_addr_n;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .i_wdata      (w_push_data),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_count      (w_fifo_count),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data)
  );

  assign mem_req                    = r_mem_req;
  assign mem_addr                   = r_mem_addr;
  assign instr_valid                = w_head_valid;
  assign {instruction_word, instr_pc} = w_head_data;

endmodule

// File: tb/tb_leg_fetch_queue.sv
// Directed and randomized checks of leg_fetch_queue against a PC-sequence reference model.
module tb_leg_fetch_queue;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction_word;
  logic [ADDR_W-1:0] instr_pc;

  logic [7:0]        img [256];
  logic [63:0]       exp_pc;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_pops   = 0;
  int                p0;

  always #5 CLK = ~CLK;

  leg_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .mem_ack          (mem_ack),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction_word (instruction_word),
    .instr_pc         (instr_pc)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Big-endian word held in the memory image at a given PC.
  function automatic logic [31:0] word_at(input logic [63:0] pc);
    logic [7:0] a;
    a = pc[7:0];
    return {img[a], img[a + 8'd1], img[a + 8'd2], img[a + 8'd3]};
  endfunction

  // One clock: serve memory, score any pop against the model, then check the address-hold rule.
  task automatic tick();
    logic        hold;
    logic [63:0] held_addr;
    mem_data  = img[mem_addr[7:0]];
    hold      = RESET_N && mem_req && !mem_ack && !redirect_valid;
    held_addr = mem_addr;
    if (RESET_N && !redirect_valid && instr_valid && instr_ready) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_word", instruction_word, word_at(exp_pc));
      exp_pc = exp_pc + 64'd4;
      n_pops++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    @(posedge CLK);
    @(negedge CLK);
    if (hold) begin
      check("addr_hold", mem_addr, held_addr);
      check("req_hold", mem_req, 1'b1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    RESET_N        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_data       = '0;
    mem_ack        = 1'b0;
    instr_ready    = 1'b0;
    exp_pc         = '0;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[0] = 8'hF8; img[1] = 8'h40; img[2] = 8'h01; img[3] = 8'h42;
    img[4] = 8'hF8; img[5] = 8'h40; img[6] = 8'h11; img[7] = 8'h43;
    img[8'h28] = 8'h14; img[8'h29] = 8'h00; img[8'h2A] = 8'h00; img[8'h2B] = 8'h03;

    // reset values
    repeat (2) @(negedge CLK);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_word", instruction_word, 32'h0);
    check("rst_pc", instr_pc, 64'h0);

    // sequential fetch, ack tied high
    mem_ack     = 1'b1;
    instr_ready = 1'b1;
    RESET_N     = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("seq_valid", instr_valid, (t == 5 || t == 9));
      if (t == 1) check("seq_addr_b0", mem_addr, 64'h0);
      if (t == 2) check("seq_addr_b1", mem_addr, 64'h1);
      if (t == 5) begin
        check("seq_word0", instruction_word, 32'hF8400142);
        check("seq_pc0", instr_pc, 64'h0);
      end
      if (t == 9) begin
        check("seq_word1", instruction_word, 32'hF8401143);
        check("seq_pc1", instr_pc, 64'h4);
      end
    end
    tick();

    // FIFO fills and stalls
    RESET_N     = 1'b0;
    instr_ready = 1'b0;
    exp_pc      = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    run(16);
    check("full_req_pre", mem_req, 1'b1);
    tick();
    check("full_req", mem_req, 1'b0);
    check("full_valid", instr_valid, 1'b1);
    check("full_head_pc", instr_pc, 64'h0);
    run(3);
    check("stall_req", mem_req, 1'b0);
    check("stall_addr", mem_addr, 64'hF);
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    check("resume_req", mem_req, 1'b1);
    check("resume_addr", mem_addr, 64'h10);
    mem_ack     = 1'b1;
    instr_ready = 1'b1;
    run(30);

    // redirect with two queued words and a half-built word, plus a same-cycle pop
    instr_ready = 1'b0;
    redirect_to(64'h0);
    check("redir0_valid", instr_valid, 1'b0);
    check("redir0_addr", mem_addr, 64'h0);
    run(10);
    check("prered_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    redirect_to(64'h28);
    instr_ready = 1'b0;
    check("redir_valid", instr_valid, 1'b0);
    check("redir_req", mem_req, 1'b1);
    check("redir_addr0", mem_addr, 64'h28);
    tick();
    check("redir_addr1", mem_addr, 64'h29);
    run(2);
    check("redir_valid_wait", instr_valid, 1'b0);
    tick();
    check("redir_head_valid", instr_valid, 1'b1);
    check("redir_word", instruction_word, 32'h14000003);
    check("redir_pc", instr_pc, 64'h28);

    // push and pop together at count 3
    run(11);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pp_req", mem_req, 1'b1);
    check("pp_head", instr_pc, 64'h2C);
    run(3);
    check("pp_req_late", mem_req, 1'b1);
    tick();
    check("pp_full_req", mem_req, 1'b0);
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    run(4);
    check("pp_drained", instr_valid, 1'b0);
    check("pp_order_end", exp_pc, 64'h3C);

    // PC wrap across 2^64
    mem_ack = 1'b1;
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    run(24);
    check("wrap_pc", exp_pc, 64'hC);

    // slow memory: ack every third cycle
    mem_ack = 1'b0;
    redirect_to(64'h40);
    p0 = n_pops;
    for (int i = 0; i < 72; i++) begin
      mem_ack = (i % 3 == 2);
      tick();
    end
    check("slow_pops", n_pops - p0, 5);

    // randomized traffic with occasional redirects
    p0 = n_pops;
    for (int i = 0; i < 400; i++) begin
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = 64'($urandom_range(0, 63)) << 2;
      mem_ack        = ($urandom_range(0, 9) < 6);
      instr_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    redirect_valid = 1'b0;
    check("rand_progress", (n_pops - p0) >= 10, 1'b1);

    // asynchronous reset in the middle of a word
    mem_ack     = 1'b1;
    instr_ready = 1'b0;
    redirect_to(64'h0);
    run(6);
    check("pre_rst_addr", mem_addr, 64'h6);
    check("pre_rst_valid", instr_valid, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_addr", mem_addr, 64'h0);
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_word", instruction_word, 32'h0);
    check("mid_rst_pc", instr_pc, 64'h0);
    @(negedge CLK);
    RESET_N     = 1'b1;
    exp_pc      = '0;
    instr_ready = 1'b1;
    tick();
    check("restart_req", mem_req, 1'b1);
    check("restart_addr", mem_addr, 64'h0);
    run(12);
    check("restart_pc", exp_pc, 64'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
